// File: rtl/duty_slew_if.sv
// -----------------------------------------------------------------------------
// duty_slew_if
// Groups the SPI-side target inputs, the PWM period strobe, the bypass control
// and the slewed duty outputs of duty_slew_ctrl into one bundle.
//   master : drives target_in, target_valid, period_start, bypass;
//            observes duty_out, ramping, done
//   slave  : the slew controller (mirror image of master)
// -----------------------------------------------------------------------------
interface duty_slew_if #(
    parameter int DUTY_W = 8
);
    logic [DUTY_W-1:0] target_in;
    logic              target_valid;
    logic              period_start;
    logic              bypass;
    logic [DUTY_W-1:0] duty_out;
    logic              ramping;
    logic              done;

    modport master (
        output target_in,
        output target_valid,
        output period_start,
        output bypass,
        input  duty_out,
        input  ramping,
        input  done
    );

    modport slave (
        input  target_in,
        input  target_valid,
        input  period_start,
        input  bypass,
        output duty_out,
        output ramping,
        output done
    );
endinterface

// File: rtl/duty_slew_ctrl.sv
// -----------------------------------------------------------------------------
// duty_slew_ctrl
// Slew-rate limiter between the SPI receiver and the PWM generator. Each rising
// edge of target_valid latches target_in as the new target; the PWM duty then
// walks toward it by at most STEP per update, one update every TICK_DIV clocks,
// and each update is applied only on a PWM period boundary (period_start).
// With bypass=1 the duty jumps straight to the target at the next boundary.
//
// Ports:
//   clk              PWM-domain clock
//   rst              asynchronous active-high reset
//   bus.target_in    duty byte from the SPI receiver
//   bus.target_valid data-received flag (pulse or level, rising edge counts)
//   bus.period_start one-cycle pulse at PWM counter wrap
//   bus.bypass       jump to target at the next boundary, no slewing
//   bus.duty_out     duty value for the PWM generator (registered)
//   bus.ramping      high whenever the FSM is not idle (registered)
//   bus.done         one-cycle pulse on the update that reaches the target
// -----------------------------------------------------------------------------
module duty_slew_ctrl #(
    parameter int DUTY_W     = 8,
    parameter int STEP       = 16,
    parameter int TICK_DIV   = 1000,
    parameter int RESET_DUTY = 0
) (
    input logic        clk,
    input logic        rst,
    duty_slew_if.slave bus
);

    localparam int                CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [DUTY_W:0]   STEP_W    = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W-1:0] RST_DUTY  = DUTY_W'(RESET_DUTY);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNT     = 2'd1,
        ST_WAIT_EDGE = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [DUTY_W-1:0] duty_q,    duty_d;
    logic [DUTY_W-1:0] target_q,  target_d;
    logic [CNT_W-1:0]  tick_q,    tick_d;
    logic              valid_q,   valid_d;
    logic              done_q,    done_d;
    logic              ramping_q, ramping_d;
    logic [DUTY_W-1:0] next_duty_s;
    logic              capture_s;

    // One clamped step from cur toward tgt. The distance is formed one bit
    // wider than the duty so the compare against STEP is a plain unsigned one
    // and the result can never overshoot the target or wrap past 0 / max.
    function automatic logic [DUTY_W-1:0] slew_step(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt
    );
        logic [DUTY_W:0] mag;
        logic [DUTY_W:0] step;
        logic            go_up;
        go_up = (tgt > cur);
        if (go_up) begin
            mag = {1'b0, tgt} - {1'b0, cur};
        end else begin
            mag = {1'b0, cur} - {1'b0, tgt};
        end
        if (mag < STEP_W) begin
            step = mag;
        end else begin
            step = STEP_W;
        end
        if (go_up) begin
            return cur + step[DUTY_W-1:0];
        end else begin
            return cur - step[DUTY_W-1:0];
        end
    endfunction

    // Target capture on the rising edge of target_valid; the FSM below always
    // works from target_q, so a capture coinciding with an update only takes
    // effect from the following step.
    always_comb begin
        valid_d   = bus.target_valid;
        capture_s = bus.target_valid & ~valid_q;
        if (capture_s) begin
            target_d = bus.target_in;
        end else begin
            target_d = target_q;
        end
    end

    // Candidate duty for the next boundary update.
    always_comb begin
        if (bus.bypass) begin
            next_duty_s = target_q;
        end else begin
            next_duty_s = slew_step(duty_q, target_q);
        end
    end

    // Next-state logic: IDLE waits for a target mismatch, COUNT paces the
    // steps, WAIT_EDGE applies the step on the next PWM period boundary.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tick_d  = tick_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (target_q == duty_q) begin
                    state_d = ST_IDLE;
                end else if (bus.bypass) begin
                    state_d = ST_WAIT_EDGE;
                end else begin
                    state_d = ST_COUNT;
                    tick_d  = {CNT_W{1'b0}};
                end
            end
            ST_COUNT: begin
                if (tick_q == TICK_LAST) begin
                    state_d = ST_WAIT_EDGE;
                    tick_d  = {CNT_W{1'b0}};
                end else begin
                    tick_d  = tick_q + CNT_W'(1);
                end
            end
            ST_WAIT_EDGE: begin
                if (bus.period_start) begin
                    duty_d = next_duty_s;
                    if (next_duty_s == target_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (bus.bypass) begin
                        state_d = ST_WAIT_EDGE;
                    end else begin
                        state_d = ST_COUNT;
                        tick_d  = {CNT_W{1'b0}};
                    end
                end else begin
                    state_d = ST_WAIT_EDGE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = {CNT_W{1'b0}};
            end
        endcase
        // ramping is registered from the next state so it drops on the very
        // cycle the final update lands, together with done.
        ramping_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            duty_q    <= RST_DUTY;
            target_q  <= RST_DUTY;
            tick_q    <= {CNT_W{1'b0}};
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ramping_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            target_q  <= target_d;
            tick_q    <= tick_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            ramping_q <= ramping_d;
        end
    end

    assign bus.duty_out = duty_q;
    assign bus.ramping  = ramping_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_duty_slew_ctrl.sv
// Directed bench for duty_slew_ctrl with STEP=16, TICK_DIV=4 and a
// period_start pulse every 10 clocks.
module tb_duty_slew_ctrl;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   tot_cnt;

    duty_slew_if #(.DUTY_W(8)) bus ();

    duty_slew_ctrl #(
        .DUTY_W    (8),
        .STEP      (16),
        .TICK_DIV  (4),
        .RESET_DUTY(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PWM period strobe: one cycle high every 10 clocks, driven on negedge
    int ps_cnt;
    initial begin
        ps_cnt = 0;
        bus.period_start = 1'b0;
        forever begin
            @(negedge clk);
            ps_cnt = (ps_cnt == 9) ? 0 : ps_cnt + 1;
            bus.period_start = (ps_cnt == 9);
        end
    end

    // Monitor: log every duty change, done pulses and ramping cycles
    logic [7:0] dq[$];
    logic [7:0] mon_prev;
    int         done_cnt;
    int         ramp_cycles;
    logic [7:0] last_done_duty;
    logic       last_done_ramp;
    initial begin
        mon_prev       = 8'h00;
        done_cnt       = 0;
        ramp_cycles    = 0;
        last_done_duty = 8'h00;
        last_done_ramp = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.duty_out !== mon_prev) begin
                dq.push_back(bus.duty_out);
                mon_prev = bus.duty_out;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                last_done_duty = bus.duty_out;
                last_done_ramp = bus.ramping;
            end
            if (bus.ramping === 1'b1) ramp_cycles++;
        end
    end

    task automatic pulse_target(input logic [7:0] v);
        @(negedge clk);
        bus.target_in    = v;
        bus.target_valid = 1'b1;
        @(negedge clk);
        bus.target_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (bus.ramping === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        tot_cnt++;
        if (n >= 300) $display("FAIL %s_timeout: ramping still %b after %0d cycles, required 0", name, bus.ramping, n);
        else pass_cnt++;
    endtask

    task automatic wait_duty(input string name, input logic [7:0] v);
        int n;
        n = 0;
        while (bus.duty_out !== v && n < 300) begin
            @(negedge clk);
            n++;
        end
        tot_cnt++;
        if (n >= 300) $display("FAIL %s_wait: duty_out %h, required %h", name, bus.duty_out, v);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #1;
        tot_cnt++; if (bus.duty_out !== 8'h00) $display("FAIL rst_duty: got %h expected 00", bus.duty_out); else pass_cnt++;
        tot_cnt++; if (bus.ramping !== 1'b0) $display("FAIL rst_ramping: got %b expected 0", bus.ramping); else pass_cnt++;
        tot_cnt++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b expected 0", bus.done); else pass_cnt++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        tot_cnt++; if (bus.duty_out !== 8'h00) $display("FAIL rst_hold_duty: got %h expected 00", bus.duty_out); else pass_cnt++;
        tot_cnt++; if (ramp_cycles !== 0) $display("FAIL rst_idle: got %0d ramping cycles expected 0", ramp_cycles); else pass_cnt++;
    endtask

    task automatic test_up_ramp();
        logic [7:0] exp[4];
        logic [7:0] got;
        int base, db;
        exp = '{8'h10, 8'h20, 8'h30, 8'h40};
        base = dq.size(); db = done_cnt;
        pulse_target(8'h40);
        wait_idle("up");
        tot_cnt++; if (dq.size() - base !== 4) $display("FAIL up_len: got %0d updates expected 4", dq.size() - base); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            got = (base + i < dq.size()) ? dq[base + i] : 8'hxx;
            tot_cnt++; if (got !== exp[i]) $display("FAIL up_step%0d: got %h expected %h", i, got, exp[i]); else pass_cnt++;
        end
        tot_cnt++; if (done_cnt - db !== 1) $display("FAIL up_done_cnt: got %0d expected 1", done_cnt - db); else pass_cnt++;
        tot_cnt++; if (last_done_duty !== 8'h40) $display("FAIL up_done_duty: got %h expected 40", last_done_duty); else pass_cnt++;
        tot_cnt++; if (last_done_ramp !== 1'b0) $display("FAIL up_ramp_at_done: got %b expected 0", last_done_ramp); else pass_cnt++;
    endtask

    task automatic test_down_clamped();
        logic [7:0] exp[2];
        logic [7:0] got;
        int base, db;
        exp = '{8'h30, 8'h25};
        base = dq.size(); db = done_cnt;
        pulse_target(8'h25);
        wait_idle("down");
        tot_cnt++; if (dq.size() - base !== 2) $display("FAIL down_len: got %0d updates expected 2", dq.size() - base); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            got = (base + i < dq.size()) ? dq[base + i] : 8'hxx;
            tot_cnt++; if (got !== exp[i]) $display("FAIL down_step%0d: got %h expected %h", i, got, exp[i]); else pass_cnt++;
        end
        tot_cnt++; if (done_cnt - db !== 1) $display("FAIL down_done_cnt: got %0d expected 1", done_cnt - db); else pass_cnt++;
    endtask

    // Level valid: target_in changes while the flag stays high; a second
    // capture would send the ramp to 0x70 instead of 0x50.
    task automatic test_level_valid();
        logic [7:0] exp[3];
        logic [7:0] got;
        int base, db;
        exp = '{8'h35, 8'h45, 8'h50};
        base = dq.size(); db = done_cnt;
        @(negedge clk);
        bus.target_in    = 8'h50;
        bus.target_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.target_in = 8'h70;
        repeat (45) @(negedge clk);
        bus.target_valid = 1'b0;
        wait_idle("level");
        tot_cnt++; if (dq.size() - base !== 3) $display("FAIL level_len: got %0d updates expected 3", dq.size() - base); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            got = (base + i < dq.size()) ? dq[base + i] : 8'hxx;
            tot_cnt++; if (got !== exp[i]) $display("FAIL level_step%0d: got %h expected %h", i, got, exp[i]); else pass_cnt++;
        end
        tot_cnt++; if (bus.duty_out !== 8'h50) $display("FAIL level_final: got %h expected 50", bus.duty_out); else pass_cnt++;
        tot_cnt++; if (done_cnt - db !== 1) $display("FAIL level_done_cnt: got %0d expected 1", done_cnt - db); else pass_cnt++;
    endtask

    task automatic test_noop();
        int base, db, rc;
        base = dq.size(); db = done_cnt; rc = ramp_cycles;
        pulse_target(8'h50);
        repeat (40) @(negedge clk);
        tot_cnt++; if (ramp_cycles - rc !== 0) $display("FAIL noop_ramping: got %0d cycles expected 0", ramp_cycles - rc); else pass_cnt++;
        tot_cnt++; if (done_cnt - db !== 0) $display("FAIL noop_done: got %0d expected 0", done_cnt - db); else pass_cnt++;
        tot_cnt++; if (dq.size() - base !== 0) $display("FAIL noop_change: got %0d changes expected 0", dq.size() - base); else pass_cnt++;
    endtask

    task automatic test_bypass();
        logic [7:0] exp[3];
        logic [7:0] got;
        int base, db;
        exp = '{8'h00, 8'hFF, 8'h00};
        base = dq.size(); db = done_cnt;
        @(negedge clk);
        bus.bypass = 1'b1;
        pulse_target(8'h00);
        wait_idle("byp0");
        pulse_target(8'hFF);
        wait_idle("bypff");
        tot_cnt++; if (last_done_duty !== 8'hFF) $display("FAIL byp_done_duty: got %h expected ff", last_done_duty); else pass_cnt++;
        tot_cnt++; if (last_done_ramp !== 1'b0) $display("FAIL byp_ramp_at_done: got %b expected 0", last_done_ramp); else pass_cnt++;
        pulse_target(8'h00);
        wait_idle("byp00");
        bus.bypass = 1'b0;
        tot_cnt++; if (dq.size() - base !== 3) $display("FAIL byp_len: got %0d updates expected 3", dq.size() - base); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            got = (base + i < dq.size()) ? dq[base + i] : 8'hxx;
            tot_cnt++; if (got !== exp[i]) $display("FAIL byp_step%0d: got %h expected %h", i, got, exp[i]); else pass_cnt++;
        end
        tot_cnt++; if (done_cnt - db !== 3) $display("FAIL byp_done_cnt: got %0d expected 3", done_cnt - db); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int rc;
        pulse_target(8'h80);
        wait_duty("arst", 8'h30);
        #2;
        rst = 1'b1;
        #1;
        tot_cnt++; if (bus.duty_out !== 8'h00) $display("FAIL arst_duty: got %h expected 00", bus.duty_out); else pass_cnt++;
        tot_cnt++; if (bus.ramping !== 1'b0) $display("FAIL arst_ramping: got %b expected 0", bus.ramping); else pass_cnt++;
        tot_cnt++; if (bus.done !== 1'b0) $display("FAIL arst_done: got %b expected 0", bus.done); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        rc = ramp_cycles;
        repeat (30) @(negedge clk);
        tot_cnt++; if (bus.duty_out !== 8'h00) $display("FAIL arst_after_duty: got %h expected 00", bus.duty_out); else pass_cnt++;
        tot_cnt++; if (ramp_cycles - rc !== 0) $display("FAIL arst_after_idle: got %0d ramping cycles expected 0", ramp_cycles - rc); else pass_cnt++;
    endtask

    task automatic test_retarget();
        logic [7:0] exp[4];
        logic [7:0] got;
        int base, db;
        exp = '{8'h10, 8'h20, 8'h10, 8'h00};
        base = dq.size(); db = done_cnt;
        pulse_target(8'h80);
        wait_duty("retgt", 8'h20);
        pulse_target(8'h00);
        wait_idle("retgt");
        tot_cnt++; if (dq.size() - base !== 4) $display("FAIL retgt_len: got %0d updates expected 4", dq.size() - base); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            got = (base + i < dq.size()) ? dq[base + i] : 8'hxx;
            tot_cnt++; if (got !== exp[i]) $display("FAIL retgt_step%0d: got %h expected %h", i, got, exp[i]); else pass_cnt++;
        end
        tot_cnt++; if (done_cnt - db !== 1) $display("FAIL retgt_done_cnt: got %0d expected 1", done_cnt - db); else pass_cnt++;
    endtask

    // Capture on the same edge as a WAIT_EDGE update: that update must still
    // head for 0x40 (0x20); only later updates head for 0x05.
    task automatic test_back_to_back();
        logic [7:0] exp[4];
        logic [7:0] got;
        int base, db;
        exp = '{8'h10, 8'h20, 8'h10, 8'h05};
        base = dq.size(); db = done_cnt;
        pulse_target(8'h40);
        wait_duty("b2b", 8'h10);
        @(posedge bus.period_start);
        bus.target_in    = 8'h05;
        bus.target_valid = 1'b1;
        @(negedge clk);
        bus.target_valid = 1'b0;
        wait_idle("b2b");
        tot_cnt++; if (dq.size() - base !== 4) $display("FAIL b2b_len: got %0d updates expected 4", dq.size() - base); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            got = (base + i < dq.size()) ? dq[base + i] : 8'hxx;
            tot_cnt++; if (got !== exp[i]) $display("FAIL b2b_step%0d: got %h expected %h", i, got, exp[i]); else pass_cnt++;
        end
        tot_cnt++; if (done_cnt - db !== 1) $display("FAIL b2b_done_cnt: got %0d expected 1", done_cnt - db); else pass_cnt++;
        tot_cnt++; if (last_done_duty !== 8'h05) $display("FAIL b2b_done_duty: got %h expected 05", last_done_duty); else pass_cnt++;
    endtask

    initial begin
        pass_cnt         = 0;
        tot_cnt          = 0;
        rst              = 1'b1;
        bus.target_in    = 8'h00;
        bus.target_valid = 1'b0;
        bus.bypass       = 1'b0;
        test_reset();
        test_up_ramp();
        test_down_clamped();
        test_level_valid();
        test_noop();
        test_bypass();
        test_async_reset();
        test_retarget();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/duty_slew_ctrl.md
Name: duty_slew_ctrl

Overview:
- Slew-rate limiter between the SPI receive stage and the PWM generator, all in the 1 MHz PWM clock domain.
- Latches each duty byte received over SPI as a target, then moves the PWM duty toward it in bounded steps.
- Applies each step only at a PWM period boundary, giving glitch-free LED brightness transitions.

Parameters:
- DUTY_W, 8, duty/target width in bits.
- STEP, 16, maximum duty change per applied update; legal range 1..2^DUTY_W-1.
- TICK_DIV, 1000, clk cycles counted between steps; must be ≥1.
- RESET_DUTY, 0, duty_out and target value after reset.

Ports:
- clk  in  1  PWM-domain clock (1 MHz).
- rst  in  1  asynchronous active-high reset.
- target_in  in  DUTY_W  duty byte from the SPI receiver.
- target_valid  in  1  SPI "data received" flag; may be a pulse or a held level, and only its rising edge counts.
- period_start  in  1  one-cycle pulse from the PWM generator at counter wrap.
- bypass  in  1  1 = jump straight to target at the next period boundary, with no slewing.
- duty_out  out  DUTY_W  duty value fed to the PWM generator.
- ramping  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse on the update cycle where duty_out reaches target.

Behaviour:
- Reset (async, immediate): duty_out=RESET_DUTY, target_reg=RESET_DUTY, state=IDLE, tick_cnt=0, valid_d=0, done=0, ramping=0.
- Target capture:
  - valid_d registers target_valid each cycle.
  - Capture occurs when target_valid=1 && valid_d=0; target_reg<=target_in, visible the next cycle.
  - A held level gives exactly one capture.
  - A new capture overrides the old target at any time, including mid-ramp.
- FSM states: IDLE, COUNT, WAIT_EDGE.
  - IDLE:
    - If target_reg==duty_out, stay in IDLE with no done pulse.
    - Else if bypass=1, go to WAIT_EDGE.
    - Else go to COUNT with tick_cnt<=0.
  - COUNT:
    - tick_cnt increments each cycle.
    - When tick_cnt==TICK_DIV-1, go to WAIT_EDGE and set tick_cnt<=0.
  - WAIT_EDGE, on period_start=1:
    - duty_out<=next_duty.
    - If next_duty==target_reg, go to IDLE and assert done for one cycle.
    - Else go to COUNT, or stay in WAIT_EDGE if bypass=1.
  - WAIT_EDGE with period_start=0: hold.
- next_duty, computed from the target_reg value at that clock edge:
  - bypass=1: next_duty=target_reg.
  - Otherwise: duty_out ± min(STEP, |target_reg−duty_out|), toward target_reg.
  - The step is clamped, never overshoots, and never wraps past 0 or 2^DUTY_W−1.
  - Difference arithmetic is DUTY_W+1 bits, unsigned compare.
- Retarget mid-ramp:
  - The ramp continues from the current duty_out toward the new target.
  - A direction reversal is permitted at the next update.
  - If the new target equals the current duty_out while in COUNT or WAIT_EDGE, the next period_start applies a zero step, then IDLE with done.
- Simultaneous capture and period_start in WAIT_EDGE: the update uses the old target_reg; the new target applies from the following step.
- bypass is sampled every cycle. Changing it mid-ramp affects only the next transition/update.
- duty_out changes only on a period_start cycle in WAIT_EDGE, or on reset.
- Latency (bypass=0, each step): capture edge +1 cycle to target_reg, +1 to COUNT, +TICK_DIV cycles, then the next period_start.

Test Plan:
- Reset behaviour: assert rst asynchronously mid-ramp (duty 0x30, target 0x80) -> duty_out=0x00, ramping=0, done=0 immediately, no clock needed; after release, FSM stays IDLE.
- Upward ramp (TICK_DIV=4, STEP=16, period_start every 10 cycles): target_in=0x40 pulse -> duty_out 0x10,0x20,0x30,0x40 on successive period_starts; single done pulse with the 0x40 update; ramping falls the same cycle.
- Clamped down-ramp: from 0x40, target 0x25 -> duty_out 0x30 then 0x25, never below 0x25; done once.
- Retarget and level valid:
  - At duty 0x20 heading to 0x80, pulse target 0x00 -> next updates 0x10, 0x00, then done.
  - Hold target_valid high for 50 cycles with target 0x50 -> exactly one capture.
- Bypass and no-op:
  - bypass=1, target 0xFF from 0x00 -> duty_out=0xFF at the first period_start, done pulse, no intermediate values.
  - Target equal to the current duty -> no ramping, no done.
- Boundary timing: capture coinciding with a period_start in WAIT_EDGE -> that update uses the old target; the following update moves toward the new target.
